// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler: FSM encoding, bus widths and
// the client-count default used by the top and the watchdog.
package draw_scheduler_pkg;

  localparam int NUM_CLIENTS_DEF = 4;
  localparam int COORD_W         = 15;  // {x[7:0], y[6:0]}
  localparam int COLOUR_W        = 9;
  localparam int TIMER_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of a client index; never zero so a single-client build still has a register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// WAIT-state timer: counts cycles while enabled and flags when the count
// reaches TIMEOUT_CYCLES-1. Clear has priority over enable.
module draw_watchdog
  import draw_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear, increment while enabled, hold at the limit.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/draw_scheduler.sv
// Frame draw scheduler: on frame_tick, visits clients 0..NUM_CLIENTS-1 in
// order, starts each enabled client, waits for its done (bounded by a
// watchdog) and muxes the selected client's VGA write port to the adapter.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_CLIENTS    = NUM_CLIENTS_DEF,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            frame_tick,
  input  logic [NUM_CLIENTS-1:0]          client_en,
  input  logic [NUM_CLIENTS-1:0]          client_done,
  input  logic [NUM_CLIENTS-1:0]          client_we,
  input  logic [COORD_W*NUM_CLIENTS-1:0]  client_coords,
  input  logic [COLOUR_W*NUM_CLIENTS-1:0] client_colour,
  output logic [NUM_CLIENTS-1:0]          enable_draw,
  output logic                            vga_WriteEn,
  output logic [COORD_W-1:0]              vga_coords,
  output logic [COLOUR_W-1:0]             vga_colour,
  output logic                            frame_done,
  output logic                            overrun,
  output logic                            timeout_err
);

  localparam int              IDX_W    = idx_width(NUM_CLIENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               overrun_q;
  logic               timeout_q;

  logic                   sel_en;
  logic                   sel_done;
  logic                   sel_we;
  logic [COORD_W-1:0]     sel_coords;
  logic [COLOUR_W-1:0]    sel_colour;
  logic [NUM_CLIENTS-1:0] sel_onehot;
  logic                   wd_expired;
  logic                   active;

  // Select the current client's signals; non-selected clients are invisible.
  always_comb begin
    sel_en     = 1'b0;
    sel_done   = 1'b0;
    sel_we     = 1'b0;
    sel_coords = '0;
    sel_colour = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_en        = client_en[i];
        sel_done      = client_done[i];
        sel_we        = client_we[i];
        sel_coords    = client_coords[i*COORD_W +: COORD_W];
        sel_colour    = client_colour[i*COLOUR_W +: COLOUR_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  draw_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (state_q == ST_START),
    .enable_i  (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  // Pass sequencing plus the sticky overrun / timeout flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: reset drops the pass outright; all control state returns to idle.
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            idx_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (!sel_en || sel_done) begin
            state_q <= ST_NEXT;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_done) begin
            state_q <= ST_NEXT;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_START;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state; the VGA mux follows the client with no latency.
  assign active      = (state_q == ST_START) || (state_q == ST_WAIT);
  assign enable_draw = ((state_q == ST_START) && sel_en) ? sel_onehot : '0;
  assign vga_WriteEn = active && sel_we;
  assign vga_coords  = vga_WriteEn ? sel_coords : '0;
  assign vga_colour  = vga_WriteEn ? sel_colour : '0;
  assign frame_done  = (state_q == ST_DONE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with 4 clients and a 16-cycle watchdog.
// Cycle c means: 1 ns after the c-th rising edge following the frame_tick sample.
module tb_draw_scheduler;

  localparam int NC = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_tick = 1'b0;
  logic [NC-1:0] client_en = '0;
  logic [NC-1:0] client_we = '0;
  logic [NC-1:0] done_drv = '0;
  logic [NC-1:0] comb_mask = '0;
  logic [NC-1:0] client_done;
  logic [15*NC-1:0] client_coords;
  logic [9*NC-1:0]  client_colour;
  logic [NC-1:0] enable_draw;
  logic          vga_WriteEn;
  logic [14:0]   vga_coords;
  logic [8:0]    vga_colour;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Combinationally-completing clients answer their own enable pulse.
  assign client_done   = done_drv | (enable_draw & comb_mask);
  assign client_coords = {15'h3333, 15'h2222, 15'h1234, 15'h0ABC};
  assign client_colour = {9'h033, 9'h022, 9'h1FF, 9'h011};

  always #5 clk = ~clk;

  draw_scheduler #(
    .NUM_CLIENTS    (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .client_en     (client_en),
    .client_done   (client_done),
    .client_we     (client_we),
    .client_coords (client_coords),
    .client_colour (client_colour),
    .enable_draw   (enable_draw),
    .vga_WriteEn   (vga_WriteEn),
    .vga_coords    (vga_coords),
    .vga_colour    (vga_colour),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  task automatic apply_reset();
    resetn     = 1'b0;
    frame_tick = 1'b0;
    client_en  = '0;
    client_we  = '0;
    done_drv   = '0;
    comb_mask  = '0;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  // Pulse frame_tick for one cycle; returns 1 ns after the sampling edge (cycle 1).
  task automatic tick_pass();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++; if (enable_draw !== '0) begin n_fail++; $display("FAIL %s enable_draw: got %b expected 0", tag, enable_draw); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done: got %b expected 0", tag, frame_done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL %s overrun: got %b expected 0", tag, overrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL %s timeout_err: got %b expected 0", tag, timeout_err); end
    n_checks++; if (vga_WriteEn !== 1'b0) begin n_fail++; $display("FAIL %s vga_WriteEn: got %b expected 0", tag, vga_WriteEn); end
    n_checks++; if (vga_coords !== '0) begin n_fail++; $display("FAIL %s vga_coords: got %h expected 0", tag, vga_coords); end
    n_checks++; if (vga_colour !== '0) begin n_fail++; $display("FAIL %s vga_colour: got %h expected 0", tag, vga_colour); end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    client_en = 4'hF;
    client_we = 4'hF;
    #2;
    check_all_zero("reset");
    apply_reset();
  endtask

  task automatic test_all_disabled();
    int done_cycle = 0;
    int done_cnt   = 0;
    apply_reset();
    tick_pass();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      #1;
      n_checks++; if (enable_draw !== '0) begin n_fail++; $display("FAIL alldis enable c%0d: got %b expected 0000", c, enable_draw); end
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = c;
      end
    end
    n_checks++; if (done_cycle != 9) begin n_fail++; $display("FAIL alldis done_cycle: got %0d expected 9", done_cycle); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL alldis done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL alldis overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single_client();
    logic [NC-1:0] exp_en;
    logic          exp_we;
    apply_reset();
    client_en = 4'b0010;
    client_we = 4'b0010;
    tick_pass();
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      // Stray done from non-selected clients at c5, real done at c8.
      done_drv = (c == 8) ? 4'b0010 : (c == 5) ? 4'b1001 : 4'b0000;
      #1;
      exp_en = (c == 3) ? 4'b0010 : 4'b0000;
      exp_we = (c >= 3) && (c <= 8);
      n_checks++; if (enable_draw !== exp_en) begin n_fail++; $display("FAIL single enable c%0d: got %b expected %b", c, enable_draw, exp_en); end
      n_checks++; if (vga_WriteEn !== exp_we) begin n_fail++; $display("FAIL single we c%0d: got %b expected %b", c, vga_WriteEn, exp_we); end
      n_checks++; if (vga_coords !== (exp_we ? 15'h1234 : 15'h0)) begin n_fail++; $display("FAIL single coords c%0d: got %h expected %h", c, vga_coords, exp_we ? 15'h1234 : 15'h0); end
      n_checks++; if (vga_colour !== (exp_we ? 9'h1FF : 9'h0)) begin n_fail++; $display("FAIL single colour c%0d: got %h expected %h", c, vga_colour, exp_we ? 9'h1FF : 9'h0); end
      n_checks++; if (frame_done !== (c == 14)) begin n_fail++; $display("FAIL single frame_done c%0d: got %b expected %b", c, frame_done, c == 14); end
    end
    done_drv = '0;
  endtask

  task automatic test_comb_done();
    logic [NC-1:0] exp_en;
    apply_reset();
    client_en = 4'b0100;
    comb_mask = 4'b0100;
    tick_pass();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      #1;
      exp_en = (c == 5) ? 4'b0100 : 4'b0000;
      n_checks++; if (enable_draw !== exp_en) begin n_fail++; $display("FAIL comb enable c%0d: got %b expected %b", c, enable_draw, exp_en); end
      n_checks++; if (frame_done !== (c == 9)) begin n_fail++; $display("FAIL comb frame_done c%0d: got %b expected %b", c, frame_done, c == 9); end
    end
    comb_mask = '0;
  endtask

  task automatic test_timeout();
    logic [NC-1:0] exp_en;
    apply_reset();
    client_en = 4'b0001;
    tick_pass();
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      #1;
      exp_en = (c == 1) ? 4'b0001 : 4'b0000;
      n_checks++; if (enable_draw !== exp_en) begin n_fail++; $display("FAIL timeout enable c%0d: got %b expected %b", c, enable_draw, exp_en); end
      n_checks++; if (timeout_err !== (c >= 18)) begin n_fail++; $display("FAIL timeout_err c%0d: got %b expected %b", c, timeout_err, c >= 18); end
      n_checks++; if (frame_done !== (c == 25)) begin n_fail++; $display("FAIL timeout frame_done c%0d: got %b expected %b", c, frame_done, c == 25); end
    end
  endtask

  task automatic test_overrun();
    int done_cnt = 0;
    int en_cnt   = 0;
    apply_reset();
    client_en = 4'b0001;
    tick_pass();
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      frame_tick = (c == 3);
      done_drv   = (c == 6) ? 4'b0001 : 4'b0000;
      #1;
      if (frame_done === 1'b1) done_cnt++;
      if (enable_draw !== '0) en_cnt++;
      n_checks++; if (overrun !== (c >= 4)) begin n_fail++; $display("FAIL overrun c%0d: got %b expected %b", c, overrun, c >= 4); end
      n_checks++; if (frame_done !== (c == 14)) begin n_fail++; $display("FAIL overrun frame_done c%0d: got %b expected %b", c, frame_done, c == 14); end
    end
    frame_tick = 1'b0;
    done_drv   = '0;
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL overrun done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (en_cnt != 1) begin n_fail++; $display("FAIL overrun enable_count: got %0d expected 1", en_cnt); end
  endtask

  task automatic test_reset_mid_pass();
    int bad = 0;
    apply_reset();
    client_en = 4'b0001;
    client_we = 4'b0001;
    tick_pass();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      frame_tick = (c == 2);
      #1;
    end
    frame_tick = 1'b0;
    n_checks++; if (vga_WriteEn !== 1'b1) begin n_fail++; $display("FAIL midrst pre we: got %b expected 1", vga_WriteEn); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL midrst pre overrun: got %b expected 1", overrun); end
    #2 resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (frame_done !== 1'b0 || enable_draw !== '0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst idle_activity: got %0d expected 0", bad); end
    tick_pass();
    #1;
    n_checks++; if (enable_draw !== 4'b0001) begin n_fail++; $display("FAIL midrst restart enable: got %b expected 0001", enable_draw); end
    n_checks++; if (vga_coords !== 15'h0ABC) begin n_fail++; $display("FAIL midrst restart coords: got %h expected 0abc", vga_coords); end
  endtask

  initial begin
    test_reset();
    test_all_disabled();
    test_single_client();
    test_comb_done();
    test_timeout();
    test_overrun();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
